// File: rtl/snn_input_loader_if.sv
// Byte-in / bit-out bus of the SNN input loader: UART receive handshake plus RAM write port.
// master = loader side, slave = UART receiver / RAM side.
interface snn_input_loader_if #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned BYTE_WIDTH = 8
);
    logic [BYTE_WIDTH-1:0] rx_data;
    logic                  rx_rdy;
    logic                  clr_rx_rdy;
    logic                  ram_data;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_we;

    modport master (
        input  rx_data,
        input  rx_rdy,
        output clr_rx_rdy,
        output ram_data,
        output ram_addr,
        output ram_we
    );

    modport slave (
        output rx_data,
        output rx_rdy,
        input  clr_rx_rdy,
        input  ram_data,
        input  ram_addr,
        input  ram_we
    );
endinterface

// File: rtl/snn_input_loader.sv
// Unpacks UART bytes into single-bit writes filling image RAM addresses 0..NUM_BITS-1.
// Optional macro SNN_LOADER_MSB_FIRST_EN: unpack each byte MSB first (default LSB first).
module snn_input_loader #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned NUM_BITS   = 784,
    parameter int unsigned BYTE_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    snn_input_loader_if.master  bus,
    output logic                busy,
    output logic                load_done
);
    localparam int unsigned CntWidth = (BYTE_WIDTH > 1) ? $clog2(BYTE_WIDTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(NUM_BITS - 1);
    localparam logic [CntWidth-1:0]   LastBit  = CntWidth'(BYTE_WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StWaitByte, StWrite, StDone} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_cnt_q, addr_cnt_d;
    logic [CntWidth-1:0]   bit_cnt_q, bit_cnt_d;
    logic [BYTE_WIDTH-1:0] shift_reg_q, shift_reg_d;
    logic                  clr_rx_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_reg_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_cnt_q  <= addr_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_reg_q <= shift_reg_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_cnt_d  = addr_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_reg_d = shift_reg_q;
        clr_rx_rdy  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StWaitByte;
                    addr_cnt_d = '0;
                end
            end
            StWaitByte: begin
                if (bus.rx_rdy) begin
                    shift_reg_d = bus.rx_data;
                    clr_rx_rdy  = 1'b1;
                    bit_cnt_d   = '0;
                    state_d     = StWrite;
                end
            end
            StWrite: begin
`ifdef SNN_LOADER_MSB_FIRST_EN
                shift_reg_d = shift_reg_q << 1;
`else
                shift_reg_d = shift_reg_q >> 1;
`endif
                bit_cnt_d = bit_cnt_q + 1'b1;
                // The last address holds so addr_cnt never runs past the image.
                if (addr_cnt_q == LastAddr) begin
                    state_d = StDone;
                end else begin
                    addr_cnt_d = addr_cnt_q + 1'b1;
                    if (bit_cnt_q == LastBit) begin
                        state_d = StWaitByte;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.clr_rx_rdy = clr_rx_rdy;
    assign bus.ram_we     = (state_q == StWrite);
    assign bus.ram_addr   = addr_cnt_q;
`ifdef SNN_LOADER_MSB_FIRST_EN
    assign bus.ram_data   = shift_reg_q[BYTE_WIDTH-1];
`else
    assign bus.ram_data   = shift_reg_q[0];
`endif
    assign busy           = (state_q != StIdle);
    assign load_done      = (state_q == StDone);

endmodule

// File: tb/tb_snn_input_loader.sv
// Randomized scoreboard bench for snn_input_loader: default image plus a 20-bit variant.
module tb_snn_input_loader;
    localparam int unsigned AW     = 10;
    localparam int unsigned NB     = 784;
    localparam int unsigned BW     = 8;
    localparam int unsigned NBYTES = (NB + BW - 1) / BW;
    localparam int unsigned AW2    = 5;
    localparam int unsigned NB2    = 20;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic rst, start, busy, load_done;
    logic start2, busy2, done2;

    snn_input_loader_if #(.ADDR_WIDTH(AW),  .BYTE_WIDTH(BW)) bus ();
    snn_input_loader_if #(.ADDR_WIDTH(AW2), .BYTE_WIDTH(BW)) bus2 ();

    snn_input_loader #(.ADDR_WIDTH(AW), .NUM_BITS(NB), .BYTE_WIDTH(BW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bus       (bus),
        .busy      (busy),
        .load_done (load_done)
    );

    snn_input_loader #(.ADDR_WIDTH(AW2), .NUM_BITS(NB2), .BYTE_WIDTH(BW)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .start     (start2),
        .bus       (bus2),
        .busy      (busy2),
        .load_done (done2)
    );

    typedef struct {
        int unsigned addr;
        bit          data;
    } wr_t;

    int checks = 0;
    int errors = 0;

    wr_t         exp_q[$];
    wr_t         got2[$];
    int          ack_times[$];
    bit          exp_img[NB];
    bit          ram[NB];
    int          byte_idx;
    int          ack_cnt = 0;
    int          done_cnt = 0;
    int          done2_cnt = 0;
    int          cyc = 0;
    logic        prev_we = 1'b0;
    logic [AW-1:0]  prev_addr = '0;
    logic        prev2_we = 1'b0;
    logic [AW2-1:0] prev2_addr = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Position i of a byte is the i-th bit written to RAM.
    function automatic bit exp_bit(input logic [7:0] b, input int i);
`ifdef SNN_LOADER_MSB_FIRST_EN
        return b[BW-1-i];
`else
        return b[i];
`endif
    endfunction

    function automatic void push_byte(input logic [7:0] b);
        for (int i = 0; i < BW; i++) begin
            int unsigned a;
            a = byte_idx * BW + i;
            if (a < NB) begin
                exp_q.push_back('{a, exp_bit(b, i)});
                exp_img[a] = exp_bit(b, i);
            end
        end
        byte_idx++;
    endfunction

    // Presents one byte after gap idle cycles and holds it until acknowledged.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit got;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        push_byte(b);
        bus.rx_data = b;
        bus.rx_rdy  = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (bus.clr_rx_rdy) got = 1'b1;
        end
        if (!got) check("ack_timeout", 64'(got), 64'(1));
        @(posedge clk);
        #1;
        bus.rx_rdy = 1'b0;
    endtask

    always @(negedge clk) begin
        if (bus.ram_we) begin
            if (bus.ram_addr < NB) ram[bus.ram_addr] = bus.ram_data;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_write: got addr %0d, no write expected", bus.ram_addr);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("wr_addr", 64'(bus.ram_addr), 64'(w.addr));
                check("wr_data", 64'(bus.ram_data), 64'(w.data));
            end
        end
        if (bus.clr_rx_rdy) begin
            ack_cnt++;
            ack_times.push_back(cyc);
        end
        if (load_done) begin
            done_cnt++;
            check("done_follows_last_write", 64'({prev_we, prev_addr}), 64'({1'b1, AW'(NB - 1)}));
            check("done_queue_empty", 64'(exp_q.size()), 64'(0));
        end
        prev_we   = bus.ram_we;
        prev_addr = bus.ram_addr;
        cyc++;
    end

    always @(negedge clk) begin
        if (bus2.ram_we) got2.push_back('{int'(bus2.ram_addr), bus2.ram_data});
        if (done2) begin
            done2_cnt++;
            check("dut2_done_follows_addr19", 64'({prev2_we, prev2_addr}),
                  64'({1'b1, AW2'(NB2 - 1)}));
        end
        prev2_we   = bus2.ram_we;
        prev2_addr = bus2.ram_addr;
    end

    task automatic run_load(input bit continuous, input bit poke_start);
        int base_ack, base_done, base_t, bad, nmis;
        bit seen;
        byte_idx  = 0;
        base_ack  = ack_cnt;
        base_done = done_cnt;
        base_t    = ack_times.size();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        fork
            begin
                for (int i = 0; i < NBYTES; i++) begin
                    if (continuous) send_byte(8'(i % 256), 0);
                    else send_byte(8'($urandom), int'($urandom_range(3)));
                end
            end
            begin
                // A start mid-load must not restart the address sequence.
                if (poke_start) begin
                    repeat (300) @(posedge clk);
                    #1;
                    start = 1'b1;
                    @(posedge clk);
                    #1;
                    start = 1'b0;
                end
            end
        join
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            if (load_done) seen = 1'b1;
        end
        check("load_done_seen", 64'(seen), 64'(1));
        @(negedge clk);
        check("idle_after_done", 64'({busy, load_done}), 64'(0));
        repeat (5) @(negedge clk);
        check("done_pulse_count", 64'(done_cnt - base_done), 64'(1));
        check("ack_count", 64'(ack_cnt - base_ack), 64'(NBYTES));
        nmis = 0;
        for (int a = 0; a < NB; a++) if (ram[a] != exp_img[a]) nmis++;
        check("readback_mismatches", 64'(nmis), 64'(0));
        if (continuous) begin
            bad = 0;
            for (int i = base_t + 1; i < ack_times.size(); i++)
                if (ack_times[i] - ack_times[i-1] != 9) bad++;
            check("ack_cadence_not_9", 64'(bad), 64'(0));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base_ack, base_done, bad2;
        bit got;
        logic [7:0] b2[3];

        rst = 1'b1;
        start = 1'b0;
        start2 = 1'b0;
        bus.rx_rdy = 1'b0;
        bus.rx_data = '0;
        bus2.rx_rdy = 1'b0;
        bus2.rx_data = '0;
        repeat (3) begin
            @(negedge clk);
            check("reset_outputs", 64'({bus.ram_we, bus.clr_rx_rdy, busy, load_done,
                                        bus.ram_data, bus.ram_addr}), 64'(0));
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.rx_data = 8'hA5;
        bus.rx_rdy = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("idle_ignores_rx", 64'({bus.ram_we, bus.clr_rx_rdy, busy}), 64'(0));
        end

        // Load A: start with a byte already pending, then abort by reset after 40 bits.
        @(posedge clk);
        #1;
        byte_idx  = 0;
        base_ack  = ack_cnt;
        base_done = done_cnt;
        push_byte(8'hA5);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("ack_after_start", 64'(bus.clr_rx_rdy), 64'(1));
        @(posedge clk);
        #1;
        bus.rx_rdy = 1'b0;
        send_byte(8'h01, 0);
        repeat (3) send_byte(8'($urandom), int'($urandom_range(3)));
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
        check("load_a_drained", 64'(exp_q.size()), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_to_idle", 64'({busy, bus.ram_we}), 64'(0));
        repeat (20) @(negedge clk);
        check("abort_no_done", 64'(done_cnt - base_done), 64'(0));
        check("load_a_acks", 64'(ack_cnt - base_ack), 64'(5));
        @(posedge clk);
        #1;

        run_load(1'b1, 1'b1);
        run_load(1'b0, 1'b0);

        // Short image: 20 bits from 3 bytes, the last byte's upper half is dropped.
        for (int i = 0; i < 3; i++) b2[i] = 8'($urandom);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus2.rx_data = b2[i];
            bus2.rx_rdy = 1'b1;
            got = 1'b0;
            for (int k = 0; k < 40 && !got; k++) begin
                @(negedge clk);
                if (bus2.clr_rx_rdy) got = 1'b1;
            end
            check("dut2_ack", 64'(got), 64'(1));
            @(posedge clk);
            #1;
            bus2.rx_rdy = 1'b0;
        end
        for (int k = 0; k < 40 && done2_cnt == 0; k++) @(negedge clk);
        repeat (10) @(negedge clk);
        check("dut2_done_count", 64'(done2_cnt), 64'(1));
        check("dut2_write_count", 64'(got2.size()), 64'(NB2));
        bad2 = 0;
        for (int i = 0; i < got2.size(); i++)
            if (got2[i].addr != i || got2[i].data != exp_bit(b2[i/BW], i % BW)) bad2++;
        check("dut2_write_mismatches", 64'(bad2), 64'(0));
        check("dut2_idle", 64'(busy2), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
